// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: N input streams share one registered output stage.
// A grant is held until the granted requester's last beat is accepted.
module stream_rr_arbiter #(
    parameter int DW  = 48,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*DW-1:0]   s_data_i,
    input  logic [N-1:0]      s_last_i,
    input  logic [N-1:0]      s_valid_i,
    output logic [N-1:0]      s_ready_o,
    output logic [DW-1:0]     m_data_o,
    output logic              m_last_o,
    output logic [IDW-1:0]    m_id_o,
    output logic              m_valid_o,
    input  logic              m_ready_i
);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    logic           state;
    logic [IDW-1:0] g;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] next_g;
    logic [IDW-1:0] cand;
    logic [IDW:0]   cand_sum;
    logic           found;
    logic           out_free;
    logic           accept;

    // Search upward from ptr, modulo N; the first valid requester wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        found    = 1'b0;
        next_g   = ptr;
        cand     = ptr;
        cand_sum = '0;
        for (int i = 0; i < N; i++) begin
            cand_sum = {1'b0, ptr} + (IDW + 1)'(i);
            if (cand_sum >= (IDW + 1)'(N)) begin
                cand_sum = cand_sum - (IDW + 1)'(N);
            end
            cand = cand_sum[IDW-1:0];
            if (!found && s_valid_i[cand]) begin
                found  = 1'b1;
                next_g = cand;
            end
        end
    end

    assign out_free = !m_valid_o || m_ready_i;
    assign accept   = (state == STATE_LOCKED) && s_valid_i[g] && out_free;

    // Ready depends only on state, grant and output occupancy, never on s_valid_i.
    always_comb begin
        s_ready_o = '0;
        if (state == STATE_LOCKED) begin
            s_ready_o[g] = out_free;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (found) begin
                        g     <= next_g;
                        state <= STATE_LOCKED;
                    end
                end
                default: begin
                    if (accept && s_last_i[g]) begin
                        state <= STATE_IDLE;
                        ptr   <= (g == IDW'(N - 1)) ? '0 : g + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
            m_id_o    <= '0;
            m_valid_o <= 1'b0;
        end else if (accept) begin
            m_data_o  <= s_data_i[g*DW +: DW];
            m_last_o  <= s_last_i[g];
            m_id_o    <= g;
            m_valid_o <= 1'b1;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus randomized
// traffic compared against a packet-level round-robin reference model.
module tb_stream_rr_arbiter;

    localparam int DW  = 48;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   s_data_i;
    logic [N-1:0]      s_last_i;
    logic [N-1:0]      s_valid_i;
    logic [N-1:0]      s_ready_o;
    logic [DW-1:0]     m_data_o;
    logic              m_last_o;
    logic [IDW-1:0]    m_id_o;
    logic              m_valid_o;
    logic              m_ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t src_q[N][$];
    exp_t  exp_q[$];
    int    out_cyc[$];

    stream_rr_arbiter #(.DW(DW), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_id_o    (m_id_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst       = 1'b1;
        s_valid_i = '0;
        s_last_i  = '0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic add_packet(input int k, input int len);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.data = rand_data();
            bt.last = (b == len - 1);
            src_q[k].push_back(bt);
        end
    endtask

    // Packet-level model: every requester with pending packets is valid when the
    // arbiter is idle, so grants follow round-robin order over non-empty sources.
    task automatic build_model();
        int   idx[N];
        int   ptr;
        int   s;
        bit   any;
        exp_t e;
        exp_q.delete();
        ptr = 0;
        for (int k = 0; k < N; k++) idx[k] = 0;
        forever begin
            any = 1'b0;
            s   = 0;
            for (int i = 0; i < N; i++) begin
                if (!any && idx[(ptr + i) % N] < src_q[(ptr + i) % N].size()) begin
                    any = 1'b1;
                    s   = (ptr + i) % N;
                end
            end
            if (!any) break;
            do begin
                e.id   = IDW'(s);
                e.data = src_q[s][idx[s]].data;
                e.last = src_q[s][idx[s]].last;
                exp_q.push_back(e);
                idx[s]++;
            end while (!e.last);
            ptr = (s + 1) % N;
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 stall in cycles 3 and 4.
    // drop_mode:  0 never, 1 random mid-packet drops, 2 requester 0 stalls 5 cycles after its first beat.
    task automatic run_traffic(input int ready_mode, input int drop_mode, input int budget);
        bit             started[N];
        int             stall[N];
        int             cyc;
        bit             prev_hold;
        logic [DW-1:0]  prev_data;
        logic [IDW-1:0] prev_id;
        logic           prev_last;
        logic [N-1:0]   others;
        exp_t           e;
        beat_t          bt;
        out_cyc.delete();
        for (int k = 0; k < N; k++) begin
            started[k] = 1'b0;
            stall[k]   = 0;
        end
        cyc       = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_id   = '0;
        prev_last = 1'b0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (stall[k] > 0) stall[k]--;
                s_valid_i[k] = (src_q[k].size() > 0) && (stall[k] == 0);
                if (drop_mode == 1 && started[k] && $urandom_range(0, 3) == 0) s_valid_i[k] = 1'b0;
                s_data_i[k*DW +: DW] = (src_q[k].size() > 0) ? src_q[k][0].data : '0;
                s_last_i[k]          = (src_q[k].size() > 0) ? src_q[k][0].last : 1'b0;
            end
            case (ready_mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = ($urandom_range(0, 9) < 7);
                default: m_ready_i = (cyc != 3 && cyc != 4);
            endcase
            #1;
            n_cmp++;
            if ($countones(s_ready_o) > 1) begin
                n_bad++;
                $display("FAIL ready_onehot: cycle %0d s_ready_o=%b, at most one bit allowed", cyc, s_ready_o);
            end
            if (m_valid_o && !m_ready_i) begin
                n_cmp++;
                if (s_ready_o !== '0) begin
                    n_bad++;
                    $display("FAIL ready_when_full: cycle %0d s_ready_o=%b, want 0", cyc, s_ready_o);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (started[k]) begin
                    others    = s_ready_o;
                    others[k] = 1'b0;
                    n_cmp++;
                    if (others !== '0) begin
                        n_bad++;
                        $display("FAIL no_interleave: cycle %0d src %0d mid-packet, s_ready_o=%b", cyc, k, s_ready_o);
                    end
                end
            end
            if (prev_hold) begin
                n_cmp++;
                if (!m_valid_o || {m_id_o, m_data_o, m_last_o} !== {prev_id, prev_data, prev_last}) begin
                    n_bad++;
                    $display("FAIL output_hold: cycle %0d got v=%b id=%0d d=%h l=%b, want held id=%0d d=%h l=%b",
                             cyc, m_valid_o, m_id_o, m_data_o, m_last_o, prev_id, prev_data, prev_last);
                end
            end
            if (m_valid_o && m_ready_i) begin
                out_cyc.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_beat: cycle %0d id=%0d d=%h, no beat expected", cyc, m_id_o, m_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_id_o, m_data_o, m_last_o} !== {e.id, e.data, e.last}) begin
                        n_bad++;
                        $display("FAIL out_beat: cycle %0d got id=%0d d=%h l=%b, want id=%0d d=%h l=%b",
                                 cyc, m_id_o, m_data_o, m_last_o, e.id, e.data, e.last);
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (s_valid_i[k] && s_ready_o[k] && src_q[k].size() > 0) begin
                    bt = src_q[k].pop_front();
                    if (drop_mode == 2 && k == 0 && !started[k] && !bt.last) stall[k] = 6;
                    started[k] = !bt.last;
                end
            end
            prev_hold = m_valid_o && !m_ready_i;
            prev_id   = m_id_o;
            prev_data = m_data_o;
            prev_last = m_last_o;
            cyc++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL traffic_timeout: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
        end
        n_cmp++;
        if (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0) begin
            n_bad++;
            $display("FAIL source_drain: beats left unaccepted %0d/%0d/%0d/%0d, want 0",
                     src_q[0].size(), src_q[1].size(), src_q[2].size(), src_q[3].size());
        end
        for (int k = 0; k < N; k++) src_q[k].delete();
        @(negedge clk);
        s_valid_i = '0;
        m_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if ({m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: v=%b l=%b d=%h id=%0d rdy=%b, want all 0",
                     m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o);
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] d;
        apply_reset();
        d = rand_data();
        @(negedge clk);
        s_valid_i            = 4'b0100;
        s_last_i             = 4'b0100;
        s_data_i[2*DW +: DW] = d;
        m_ready_i            = 1'b1;
        #1;
        n_cmp++;
        if (s_ready_o !== 4'b0000) begin
            n_bad++; $display("FAIL lat_idle_ready: got %b want 0000", s_ready_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({s_ready_o, m_valid_o} !== {4'b0100, 1'b0}) begin
            n_bad++; $display("FAIL lat_grant: got rdy=%b v=%b want rdy=0100 v=0", s_ready_o, m_valid_o);
        end
        @(negedge clk);
        s_valid_i = '0;
        #1;
        n_cmp++;
        if ({m_valid_o, m_id_o, m_data_o, m_last_o} !== {1'b1, 2'd2, d, 1'b1}) begin
            n_bad++;
            $display("FAIL lat_output: got v=%b id=%0d d=%h l=%b want v=1 id=2 d=%h l=1",
                     m_valid_o, m_id_o, m_data_o, m_last_o, d);
        end
        n_cmp++;
        if (s_ready_o !== 4'b0000) begin
            n_bad++; $display("FAIL single_beat_idle: got %b want 0000", s_ready_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (m_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL valid_clear: got %b want 0", m_valid_o);
        end
    endtask

    task automatic test_fairness();
        int want;
        apply_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N; k++) add_packet(k, 3);
        build_model();
        run_traffic(0, 0, 200);
        n_cmp++;
        if (out_cyc.size() != 24) begin
            n_bad++; $display("FAIL fair_count: got %0d beats want 24", out_cyc.size());
        end
        for (int i = 0; i < out_cyc.size(); i++) begin
            want = (i == 0) ? 2 : out_cyc[i-1] + ((i % 3 == 0) ? 2 : 1);
            n_cmp++;
            if (out_cyc[i] != want) begin
                n_bad++; $display("FAIL fair_timing: beat %0d at cycle %0d want %0d", i, out_cyc[i], want);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            add_packet(3, 2);
            add_packet(1, 2);
        end
        build_model();
        run_traffic(1, 0, 300);
    endtask

    task automatic test_backpressure();
        int want_cyc[4] = '{2, 5, 6, 7};
        apply_reset();
        add_packet(2, 4);
        build_model();
        run_traffic(2, 0, 100);
        n_cmp++;
        if (out_cyc.size() != 4) begin
            n_bad++; $display("FAIL bp_count: got %0d beats want 4", out_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (out_cyc[i] != want_cyc[i]) begin
                    n_bad++; $display("FAIL bp_timing: beat %0d at cycle %0d want %0d", i, out_cyc[i], want_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_no_interleave();
        apply_reset();
        add_packet(0, 4);
        add_packet(1, 2);
        build_model();
        run_traffic(0, 2, 100);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        m_ready_i = 1'b1;
        s_valid_i = 4'b0100;
        s_last_i  = 4'b0100;
        s_data_i  = {N{rand_data()}};
        repeat (2) @(negedge clk);
        s_last_i = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({m_valid_o, s_ready_o} !== {1'b1, 4'b0100}) begin
            n_bad++; $display("FAIL rst_mid_pre: got v=%b rdy=%b want v=1 rdy=0100", m_valid_o, s_ready_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid_o, s_ready_o, m_data_o} !== '0) begin
            n_bad++; $display("FAIL rst_mid_clear: got v=%b rdy=%b d=%h want 0", m_valid_o, s_ready_o, m_data_o);
        end
        s_valid_i = 4'b1010;
        s_last_i  = 4'b1010;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (s_ready_o !== 4'b0000) begin
            n_bad++; $display("FAIL rst_mid_idle: got %b want 0000", s_ready_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (s_ready_o !== 4'b0010) begin
            n_bad++; $display("FAIL rst_mid_regrant: got %b want 0010", s_ready_o);
        end
        s_valid_i = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int p = 0; p < int'($urandom_range(1, 6)); p++) add_packet(k, $urandom_range(1, 4));
                end
            end
            build_model();
            run_traffic(1, 1, 3000);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fairness();
        test_pointer_wrap();
        test_backpressure();
        test_no_interleave();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
